// File: rtl/vpf_decode1536_if.sv
// Pad-address stream in, completed VPF mask and frame statistics out.
// The decoder takes the slave side; whatever feeds the address stream takes the master side.
interface vpf_decode1536_if #(
    parameter int MXKEYS    = 1536,
    parameter int MXKEYBITS = 11
);
    logic [MXKEYBITS-1:0] adr;
    logic                 adr_valid;
    logic                 frame;
    logic [MXKEYS-1:0]    vpfs;
    logic                 vpfs_valid;
    logic [MXKEYBITS-1:0] nhits;
    logic                 dup;
    logic                 oor;
    logic [MXKEYBITS-1:0] first_adr;

    modport master (
        output adr, adr_valid, frame,
        input  vpfs, vpfs_valid, nhits, dup, oor, first_adr
    );

    modport slave (
        input  adr, adr_valid, frame,
        output vpfs, vpfs_valid, nhits, dup, oor, first_adr
    );
endinterface

// File: rtl/vpf_decode1536.sv
// Pad-address to 1536-bit VPF mask decoder; accumulates one address per clock and emits the mask on frame.
// Optional VPF_DECODE_FIRST_ADR_EN builds lowest-pad tracking for first_adr.
module vpf_decode1536 #(
    parameter int                   MXKEYS    = 1536,
    parameter int                   MXKEYBITS = 11,
    parameter logic [MXKEYBITS-1:0] NULL_ADR  = 11'h7FE
) (
    input  logic                    clock,
    input  logic                    reset,
    vpf_decode1536_if.slave         bus
);
    localparam logic [MXKEYBITS-1:0] KEY_LIMIT = MXKEYBITS'(MXKEYS);

    logic [MXKEYS-1:0]    acc;
    logic [MXKEYS-1:0]    acc_nxt;
    logic [MXKEYBITS-1:0] cnt;
    logic [MXKEYBITS-1:0] cnt_nxt;
    logic                 dup_acc;
    logic                 dup_nxt;
    logic                 oor_acc;
    logic                 oor_nxt;
    logic                 hit;
    logic                 already;

    // The current cycle's address is merged here so that frame can close over it in the same clock.
    always_comb begin
        hit     = bus.adr_valid && (bus.adr < KEY_LIMIT);
        already = hit && acc[bus.adr];
        acc_nxt = acc;
        cnt_nxt = cnt;
        dup_nxt = dup_acc;
        oor_nxt = oor_acc | (bus.adr_valid && !hit && (bus.adr != NULL_ADR));
        if (hit) begin
            acc_nxt[bus.adr] = 1'b1;
            if (already) begin
                dup_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + MXKEYBITS'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            cnt     <= '0;
            dup_acc <= 1'b0;
            oor_acc <= 1'b0;
        end else if (bus.frame) begin
            acc     <= '0;
            cnt     <= '0;
            dup_acc <= 1'b0;
            oor_acc <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            dup_acc <= dup_nxt;
            oor_acc <= oor_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.vpfs       <= '0;
            bus.vpfs_valid <= 1'b0;
            bus.nhits      <= '0;
            bus.dup        <= 1'b0;
            bus.oor        <= 1'b0;
        end else begin
            bus.vpfs_valid <= bus.frame;
            if (bus.frame) begin
                bus.vpfs  <= acc_nxt;
                bus.nhits <= cnt_nxt;
                bus.dup   <= dup_nxt;
                bus.oor   <= oor_nxt;
            end
        end
    end

`ifdef VPF_DECODE_FIRST_ADR_EN
    logic [MXKEYBITS-1:0] min_acc;
    logic [MXKEYBITS-1:0] min_nxt;

    // NULL_ADR sorts above every legal pad, so it doubles as the empty-frame value.
    always_comb begin
        min_nxt = min_acc;
        if (hit && (bus.adr < min_acc)) begin
            min_nxt = bus.adr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_acc       <= NULL_ADR;
            bus.first_adr <= NULL_ADR;
        end else if (bus.frame) begin
            min_acc       <= NULL_ADR;
            bus.first_adr <= min_nxt;
        end else begin
            min_acc       <= min_nxt;
        end
    end
`else
    assign bus.first_adr = NULL_ADR;
`endif
endmodule

// File: tb/tb_vpf_decode1536.sv
// Self-checking bench for vpf_decode1536: directed scenarios plus randomized stream against a set-based model.
// Build with VPF_DECODE_FIRST_ADR_EN defined to check first_adr tracking.
module tb_vpf_decode1536;
    localparam int          MXKEYS   = 1536;
    localparam logic [10:0] NULL_ADR = 11'h7FE;

    logic clock = 1'b0;
    logic reset = 1'b0;

    vpf_decode1536_if #(.MXKEYS(MXKEYS), .MXKEYBITS(11)) bus ();

    vpf_decode1536 #(.MXKEYS(MXKEYS), .MXKEYBITS(11), .NULL_ADR(NULL_ADR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: the frame is the list of accepted addresses; statistics derive from it at close.
    int                frame_q[$];
    bit                m_oor;
    logic [MXKEYS-1:0] exp_vpfs;
    int                exp_nhits;
    bit                exp_dup;
    bit                exp_oor;
    bit                exp_valid;
    int                exp_first;

    task automatic model_reset();
        frame_q.delete();
        m_oor     = 1'b0;
        exp_vpfs  = '0;
        exp_nhits = 0;
        exp_dup   = 1'b0;
        exp_oor   = 1'b0;
        exp_valid = 1'b0;
        exp_first = NULL_ADR;
    endtask

    // Drive one cycle at the falling edge, then update the model at #1 after the rising edge.
    task automatic step(input bit v, input int a, input bit f);
        logic [31:0] aw;
        @(negedge clock);
        aw            = a;
        bus.adr_valid = v;
        bus.adr       = aw[10:0];
        bus.frame     = f;
        @(posedge clock);
        #1;
        if (v && a < MXKEYS) frame_q.push_back(a);
        else if (v && a != NULL_ADR) m_oor = 1'b1;
        exp_valid = f;
        if (f) begin
            exp_vpfs = '0;
            foreach (frame_q[i]) exp_vpfs[frame_q[i]] = 1'b1;
            exp_nhits = $countones(exp_vpfs);
            exp_dup   = (frame_q.size() != exp_nhits);
            exp_oor   = m_oor;
            exp_first = NULL_ADR;
`ifdef VPF_DECODE_FIRST_ADR_EN
            foreach (frame_q[i]) if (frame_q[i] < exp_first) exp_first = frame_q[i];
`endif
            frame_q.delete();
            m_oor = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        bus.adr_valid = 1'b0;
        bus.adr       = '0;
        bus.frame     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr} !== {1'b0, 11'd0, 1'b0, 1'b0, NULL_ADR}) begin
            failures++;
            $display("FAIL reset_status got %h want %h", {bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr},
                     {1'b0, 11'd0, 1'b0, 1'b0, NULL_ADR});
        end
        checks++;
        if (bus.vpfs !== '0) begin
            failures++;
            $display("FAIL reset_vpfs got %0d bits set want 0", $countones(bus.vpfs));
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_empty_frame();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            if (bus.vpfs_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL idle_valid got %0d pulses want 0", pulses);
        end
        step(0, 0, 1);
        checks++;
        if ({bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr} !== {1'b1, 11'd0, 1'b0, 1'b0, 11'h7FE}) begin
            failures++;
            $display("FAIL empty_frame_status got %h want %h", {bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr},
                     {1'b1, 11'd0, 1'b0, 1'b0, 11'h7FE});
        end
        checks++;
        if (bus.vpfs !== '0) begin
            failures++;
            $display("FAIL empty_frame_vpfs got %0d bits want 0", $countones(bus.vpfs));
        end
        step(0, 0, 0);
        checks++;
        if (bus.vpfs_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_frame_pulse_width got %b want 0", bus.vpfs_valid);
        end
    endtask

    task automatic test_basic_frame();
        logic [MXKEYS-1:0] want;
        logic [10:0]       want_first;
        want = '0;
        want[0] = 1'b1; want[5] = 1'b1; want[700] = 1'b1; want[1535] = 1'b1;
`ifdef VPF_DECODE_FIRST_ADR_EN
        want_first = 11'd0;
`else
        want_first = 11'h7FE;
`endif
        step(1, 5, 0);
        step(1, 1535, 0);
        step(1, 0, 0);
        checks++;
        if (bus.vpfs_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_early_valid got %b want 0", bus.vpfs_valid);
        end
        step(1, 700, 1);
        checks++;
        if (bus.vpfs !== want) begin
            failures++;
            $display("FAIL basic_vpfs got %0d bits (b700=%b b1535=%b) want bits {0,5,700,1535}",
                     $countones(bus.vpfs), bus.vpfs[700], bus.vpfs[1535]);
        end
        checks++;
        if ({bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr} !== {1'b1, 11'd4, 1'b0, 1'b0, want_first}) begin
            failures++;
            $display("FAIL basic_status got %h want %h", {bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr},
                     {1'b1, 11'd4, 1'b0, 1'b0, want_first});
        end
    endtask

    task automatic test_dup();
        logic [MXKEYS-1:0] want;
        want = '0;
        want[12] = 1'b1;
        step(1, 12, 0);
        step(1, 12, 0);
        step(1, 12, 0);
        step(0, 0, 1);
        checks++;
        if (bus.vpfs !== want || bus.nhits !== 11'd1 || bus.dup !== 1'b1) begin
            failures++;
            $display("FAIL dup_frame got bits=%0d nhits=%0d dup=%b want bits=1 nhits=1 dup=1",
                     $countones(bus.vpfs), bus.nhits, bus.dup);
        end
        step(0, 0, 1);
        checks++;
        if (bus.dup !== 1'b0 || bus.vpfs_valid !== 1'b1) begin
            failures++;
            $display("FAIL dup_cleared got dup=%b valid=%b want dup=0 valid=1", bus.dup, bus.vpfs_valid);
        end
    endtask

    task automatic test_oor();
        step(1, 11'h7FE, 0);
        step(1, 11'h600, 0);
        step(0, 0, 1);
        checks++;
        if (bus.vpfs !== '0 || bus.nhits !== 11'd0 || bus.oor !== 1'b1) begin
            failures++;
            $display("FAIL oor_frame got bits=%0d nhits=%0d oor=%b want bits=0 nhits=0 oor=1",
                     $countones(bus.vpfs), bus.nhits, bus.oor);
        end
        step(1, 11'h7FE, 1);
        checks++;
        if (bus.oor !== 1'b0 || bus.vpfs_valid !== 1'b1 || bus.vpfs !== '0) begin
            failures++;
            $display("FAIL null_only got oor=%b valid=%b bits=%0d want oor=0 valid=1 bits=0",
                     bus.oor, bus.vpfs_valid, $countones(bus.vpfs));
        end
    endtask

    task automatic test_back_to_back();
        logic [MXKEYS-1:0] w3, w9;
        w3 = '0; w3[3] = 1'b1;
        w9 = '0; w9[9] = 1'b1;
        step(1, 3, 1);
        checks++;
        if (bus.vpfs_valid !== 1'b1 || bus.vpfs !== w3) begin
            failures++;
            $display("FAIL b2b_first got valid=%b bits=%0d b3=%b want valid=1 only bit 3",
                     bus.vpfs_valid, $countones(bus.vpfs), bus.vpfs[3]);
        end
        step(1, 9, 1);
        checks++;
        if (bus.vpfs_valid !== 1'b1 || bus.vpfs !== w9 || bus.nhits !== 11'd1) begin
            failures++;
            $display("FAIL b2b_second got valid=%b bits=%0d b9=%b nhits=%0d want valid=1 only bit 9 nhits=1",
                     bus.vpfs_valid, $countones(bus.vpfs), bus.vpfs[9], bus.nhits);
        end
    endtask

    task automatic test_reset_midframe();
        logic [MXKEYS-1:0] w300;
        int pulses = 0;
        w300 = '0; w300[300] = 1'b1;
        step(1, 100, 0);
        step(1, 200, 0);
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        if (bus.vpfs_valid !== 1'b0) pulses++;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if (pulses != 0 || bus.vpfs !== '0) begin
            failures++;
            $display("FAIL midreset_clear got pulses=%0d bits=%0d want pulses=0 bits=0", pulses, $countones(bus.vpfs));
        end
        step(1, 300, 1);
        checks++;
        if (bus.vpfs_valid !== 1'b1 || bus.vpfs !== w300 || bus.nhits !== 11'd1) begin
            failures++;
            $display("FAIL midreset_frame got valid=%b bits=%0d nhits=%0d want valid=1 only bit 300 nhits=1",
                     bus.vpfs_valid, $countones(bus.vpfs), bus.nhits);
        end
    endtask

    task automatic test_random();
        int a;
        int sel;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 12) a = int'($urandom_range(0, 47));
            else if (sel < 15) a = int'($urandom_range(1488, 1535));
            else if (sel < 17) a = NULL_ADR;
            else a = int'($urandom_range(1536, 2047));
            step(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 9) == 0));
            checks++;
            if ({bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr} !==
                {exp_valid, 11'(exp_nhits), exp_dup, exp_oor, 11'(exp_first)}) begin
                failures++;
                $display("FAIL random_status cycle %0d got %h want %h", n,
                         {bus.vpfs_valid, bus.nhits, bus.dup, bus.oor, bus.first_adr},
                         {exp_valid, 11'(exp_nhits), exp_dup, exp_oor, 11'(exp_first)});
            end
            checks++;
            if (bus.vpfs !== exp_vpfs) begin
                failures++;
                $display("FAIL random_vpfs cycle %0d got %0d bits want %0d bits", n,
                         $countones(bus.vpfs), $countones(exp_vpfs));
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_basic_frame();
        test_dup();
        test_oor();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
